// File: rtl/dmem_bridge_pkg.sv
// Shared definitions for the data-side memory bridge: FSM encoding and the
// default load value returned when a bus access times out.
package dmem_bridge_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RESP = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam logic [31:0] ERR_DATA_DEFAULT = 32'hDEADBEEF;

endpackage

// File: rtl/dmem_bridge.sv
// Bridges the core's single-cycle M-stage memory port onto a valid/ready
// request + response bus, stalling the pipeline while an access is outstanding.
module dmem_bridge
  import dmem_bridge_pkg::*;
#(
  parameter int                ADDR_W   = 32,
  parameter int                DATA_W   = 32,
  parameter int                TIMEOUT  = 255,
  parameter logic [DATA_W-1:0] ERR_DATA = ERR_DATA_DEFAULT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_read_en,
  input  logic              i_write_en,
  input  logic [ADDR_W-1:0] i_memaddr,
  input  logic [DATA_W-1:0] i_write_data,
  output logic [DATA_W-1:0] o_read_data,
  output logic              o_exstall,
  output logic              o_bus_valid,
  input  logic              i_bus_ready,
  output logic              o_bus_we,
  output logic [ADDR_W-1:0] o_bus_addr,
  output logic [DATA_W-1:0] o_bus_wdata,
  input  logic              i_bus_rvalid,
  input  logic [DATA_W-1:0] i_bus_rdata,
  output logic              o_err
);

  localparam int            CW       = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] TMO_LAST = CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  state_t        state, state_nx;
  logic [CW-1:0] cnt;
  logic          req;
  logic          busy;
  logic          tmo;

  always_comb begin
    req         = i_read_en | i_write_en;
    busy        = (state == REQ) || (state == RESP);
    tmo         = (TIMEOUT != 0) && busy && (cnt == TMO_LAST);
    state_nx    = state;
    o_bus_valid = 1'b0;
    o_exstall   = 1'b0;
    o_err       = 1'b0;
    case (state)
      IDLE: begin
        o_exstall = req;
        if (req) state_nx = REQ;
      end
      REQ: begin
        o_exstall = 1'b1;
        if (tmo) begin
          // Withdraw the request so the abort cannot coincide with a handshake.
          state_nx = DONE;
          o_err    = 1'b1;
        end else begin
          o_bus_valid = 1'b1;
          if (i_bus_ready) state_nx = RESP;
        end
      end
      RESP: begin
        o_exstall = 1'b1;
        if (tmo) begin
          state_nx = DONE;
          o_err    = 1'b1;
        end else if (i_bus_rvalid) begin
          state_nx = DONE;
        end
      end
      DONE: state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      cnt         <= '0;
      o_bus_we    <= 1'b0;
      o_bus_addr  <= '0;
      o_bus_wdata <= '0;
      o_read_data <= '0;
    end else begin
      state <= state_nx;
      if (state == IDLE) begin
        cnt <= '0;
        if (req) begin
          o_bus_we    <= i_write_en;
          o_bus_addr  <= i_memaddr;
          o_bus_wdata <= i_write_data;
        end
      end else if (busy) begin
        cnt <= cnt + CW'(1);
      end
      // Load data lands in DONE, the cycle the core's M->W register samples it.
      if (tmo && !o_bus_we)
        o_read_data <= ERR_DATA;
      else if ((state == RESP) && i_bus_rvalid && !o_bus_we)
        o_read_data <= i_bus_rdata;
    end
  end

endmodule
